// File: rtl/vram_arbiter.sv
// Port-A arbiter for the tile frame-buffer RAM: GPU reads by default, Z80 accesses
// stall the CPU through cpu_wait_n, and a starvation counter forces a CPU grant.
module vram_arbiter #(
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned CPU_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_sel,
   input  logic              cpu_mreq_n,
   input  logic              cpu_rd_n,
   input  logic              cpu_wr_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_wait_n,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              gpu_req,
   input  logic [ADDR_W-1:0] gpu_addr,
   output logic              gpu_gnt,
   output logic [DATA_W-1:0] gpu_rdata,
   output logic              gpu_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int unsigned WCNT_W = $clog2(CPU_MAX_WAIT + 1);

   logic              w_cpu_act;
   logic              w_bus_end;
   logic              w_cpu_req;
   logic              w_cpu_force;
   logic              w_gpu_win;
   logic              w_cpu_win;
   logic              w_rd_issue;
   logic              w_cap_cpu;
   logic              w_cap_gpu;

   logic              r_served;
   logic              r_cpu_busy;
   logic              r_cpu_stale;
   logic [WCNT_W-1:0] r_wcnt;
   logic [RD_LAT-1:0] r_pv;
   logic [RD_LAT-1:0] r_po;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_gpu_rdata;
   logic              r_cpu_rvalid;
   logic              r_gpu_rvalid;

   // Grant decision; reset_n gates the grants so outputs sit at reset values during reset.
   always_comb begin
      w_cpu_act   = reset_n & cpu_sel & ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
      w_bus_end   = cpu_mreq_n | ~cpu_sel;
      w_cpu_req   = w_cpu_act & ~r_served;
      w_cpu_force = w_cpu_req & (r_wcnt >= WCNT_W'(CPU_MAX_WAIT));
      w_gpu_win   = reset_n & gpu_req & ~w_cpu_force;
      w_cpu_win   = ~w_gpu_win & w_cpu_req & ~r_cpu_busy;
      w_rd_issue  = w_gpu_win | (w_cpu_win & cpu_wr_n);
      w_cap_cpu   = r_pv[RD_LAT-1] & r_po[RD_LAT-1];
      w_cap_gpu   = r_pv[RD_LAT-1] & ~r_po[RD_LAT-1];

      gpu_gnt     = w_gpu_win;
      ram_en      = w_gpu_win | w_cpu_win;
      ram_we      = w_cpu_win & ~cpu_wr_n;
      ram_addr    = r_addr;
      ram_din     = r_din;
      if (w_gpu_win) begin
         ram_addr = gpu_addr;
      end else if (w_cpu_win) begin
         ram_addr = cpu_addr;
         ram_din  = cpu_dout;
      end
      cpu_wait_n  = ~w_cpu_req;
   end

   assign cpu_rdata  = r_cpu_rdata;
   assign cpu_rvalid = r_cpu_rvalid;
   assign gpu_rdata  = r_gpu_rdata;
   assign gpu_rvalid = r_gpu_rvalid;

   // Return pipeline, bus-cycle bookkeeping and starvation counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_served     <= 1'b0;
         r_cpu_busy   <= 1'b0;
         r_cpu_stale  <= 1'b0;
         r_wcnt       <= '0;
         r_pv         <= '0;
         r_po         <= '0;
         r_addr       <= '0;
         r_din        <= '0;
         r_cpu_rdata  <= '0;
         r_gpu_rdata  <= '0;
         r_cpu_rvalid <= 1'b0;
         r_gpu_rvalid <= 1'b0;
      end else begin
         if (ram_en) begin
            r_addr <= ram_addr;
         end
         if (w_cpu_win) begin
            r_din <= cpu_dout;
         end

         r_pv <= RD_LAT'({r_pv, w_rd_issue});
         r_po <= RD_LAT'({r_po, w_cpu_win});

         if (w_cap_cpu) begin
            r_cpu_rdata <= ram_dout;
         end
         if (w_cap_gpu) begin
            r_gpu_rdata <= ram_dout;
         end
         r_cpu_rvalid <= w_cap_cpu;
         r_gpu_rvalid <= w_cap_gpu;

         // A read whose bus cycle ended early must not mark a later bus cycle as served.
         if (w_bus_end) begin
            r_served <= 1'b0;
         end else if (w_cpu_win & ~cpu_wr_n) begin
            r_served <= 1'b1;
         end else if (w_cap_cpu & ~r_cpu_stale) begin
            r_served <= 1'b1;
         end

         if (w_cpu_win & cpu_wr_n) begin
            r_cpu_busy <= 1'b1;
         end else if (w_cap_cpu) begin
            r_cpu_busy <= 1'b0;
         end

         if (w_cap_cpu) begin
            r_cpu_stale <= 1'b0;
         end else if (r_cpu_busy & w_bus_end) begin
            r_cpu_stale <= 1'b1;
         end

         if (w_bus_end | w_cpu_win) begin
            r_wcnt <= '0;
         end else if (w_cpu_req & (r_wcnt < WCNT_W'(CPU_MAX_WAIT))) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a behavioural RAM, a shadow memory and
// cycle expectations derived from the grant/latency rules, with randomized traffic.
module tb_vram_arbiter;

   localparam int unsigned ADDR_W       = 11;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned RD_LAT       = 1;
   localparam int unsigned CPU_MAX_WAIT = 4;
   localparam int unsigned DEPTH        = 1 << ADDR_W;

   logic              clk;
   logic              reset_n;
   logic              cpu_sel, cpu_mreq_n, cpu_rd_n, cpu_wr_n;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_dout;
   logic              cpu_wait_n;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              gpu_req;
   logic [ADDR_W-1:0] gpu_addr;
   logic              gpu_gnt;
   logic [DATA_W-1:0] gpu_rdata;
   logic              gpu_rvalid;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   logic              pl_we;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;
   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   vram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CPU_MAX_WAIT(CPU_MAX_WAIT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_sel(cpu_sel), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt),
      .gpu_rdata(gpu_rdata), .gpu_rvalid(gpu_rvalid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM, one cycle address-to-dout; pl_* is a bench-only preload path.
   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout      <= mem[ram_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle;
      cpu_sel    = 1'b0;
      cpu_mreq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
   endtask

   task automatic cpu_start(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic rd, input logic wr);
      cpu_sel    = 1'b1;
      cpu_mreq_n = 1'b0;
      cpu_rd_n   = ~rd;
      cpu_wr_n   = ~wr;
      cpu_addr   = a;
      cpu_dout   = d;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_we   = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic test_reset;
      logic [40:0] obs;
      repeat (2) tick();
      @(negedge clk);
      obs = {cpu_wait_n, gpu_gnt, ram_en, ram_we, ram_addr, ram_din, cpu_rdata, cpu_rvalid, gpu_rdata, gpu_rvalid};
      n_vec++; if (obs !== {1'b1, 40'b0}) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, {1'b1, 40'b0}); end
      gpu_req = 1'b1; gpu_addr = 11'h155;
      cpu_start(11'h2AA, 8'h5A, 1'b0, 1'b1);
      #1;
      obs = {cpu_wait_n, gpu_gnt, ram_en, ram_we, ram_addr, ram_din, cpu_rdata, cpu_rvalid, gpu_rdata, gpu_rvalid};
      n_vec++; if (obs !== {1'b1, 40'b0}) begin n_err++; $display("FAIL reset_busy_inputs: got %h want %h", obs, {1'b1, 40'b0}); end
      gpu_req = 1'b0;
      cpu_idle();
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      obs = {cpu_wait_n, gpu_gnt, ram_en, ram_we, ram_addr, ram_din, cpu_rdata, cpu_rvalid, gpu_rdata, gpu_rvalid};
      n_vec++; if (obs !== {1'b1, 40'b0}) begin n_err++; $display("FAIL reset_release: got %h want %h", obs, {1'b1, 40'b0}); end
      tick();
   endtask

   task automatic test_cpu_write;
      for (int it = 0; it < 4; it++) begin
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         logic [21:0]       obs, exp;
         a = (it == 0) ? 11'h123 : ADDR_W'($urandom);
         d = (it == 0) ? 8'hA5   : DATA_W'($urandom);
         cpu_start(a, d, it == 3, 1'b1);
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            obs = {cpu_wait_n, ram_en, ram_we, ram_addr, ram_din};
            exp = (c == 0) ? {1'b0, 1'b1, 1'b1, a, d} : {1'b1, 1'b0, 1'b0, a, d};
            n_vec++; if (obs !== exp) begin n_err++; $display("FAIL cpu_write[%0d] c%0d: got %h want %h", it, c, obs, exp); end
            tick();
         end
         cpu_idle();
         ref_mem[a] = d;
         tick();
      end
   endtask

   task automatic test_cpu_read;
      for (int it = 0; it < 4; it++) begin
         logic [ADDR_W-1:0] a;
         logic [3:0]        obs, exp;
         a = (it == 0) ? 11'h040 : ADDR_W'($urandom);
         if (it == 0) preload(a, 8'h3C);
         cpu_start(a, 8'h00, 1'b1, 1'b0);
         for (int c = 0; c <= int'(RD_LAT) + 2; c++) begin
            @(negedge clk);
            obs = {cpu_wait_n, ram_en, ram_we, cpu_rvalid};
            exp = {c > int'(RD_LAT), c == 0, 1'b0, c == int'(RD_LAT) + 1};
            n_vec++; if (obs !== exp) begin n_err++; $display("FAIL cpu_read[%0d] c%0d: got %b want %b", it, c, obs, exp); end
            if (c == 0) begin
               n_vec++; if (ram_addr !== a) begin n_err++; $display("FAIL cpu_read_addr[%0d]: got %h want %h", it, ram_addr, a); end
            end
            if (c > int'(RD_LAT)) begin
               n_vec++; if (cpu_rdata !== ref_mem[a]) begin n_err++; $display("FAIL cpu_rdata[%0d] c%0d: got %h want %h", it, c, cpu_rdata, ref_mem[a]); end
            end
            tick();
         end
         cpu_idle();
         tick();
      end
   endtask

   task automatic test_gpu_stream;
      for (int it = 0; it < 2; it++) begin
         logic [ADDR_W-1:0] base;
         logic [ADDR_W-1:0] ra;
         logic              exp_rv;
         base = (it == 0) ? 11'h000 : ADDR_W'($urandom);
         for (int c = 0; c < 16 + int'(RD_LAT) + 3; c++) begin
            gpu_req  = (c < 16);
            gpu_addr = ADDR_W'(int'(base) + c);
            @(negedge clk);
            n_vec++; if (gpu_gnt !== (c < 16)) begin n_err++; $display("FAIL gpu_stream_gnt[%0d] c%0d: got %b want %b", it, c, gpu_gnt, c < 16); end
            exp_rv = (c >= int'(RD_LAT) + 1) && (c < 16 + int'(RD_LAT) + 1);
            n_vec++; if (gpu_rvalid !== exp_rv) begin n_err++; $display("FAIL gpu_stream_rvalid[%0d] c%0d: got %b want %b", it, c, gpu_rvalid, exp_rv); end
            if (exp_rv) begin
               ra = ADDR_W'(int'(base) + c - int'(RD_LAT) - 1);
               n_vec++; if (gpu_rdata !== ref_mem[ra]) begin n_err++; $display("FAIL gpu_stream_data[%0d] c%0d: got %h want %h", it, c, gpu_rdata, ref_mem[ra]); end
            end
            tick();
         end
      end
   endtask

   task automatic test_gpu_random;
      int                due_q[$];
      logic [ADDR_W-1:0] addr_q[$];
      logic              req, exp_rv;
      for (int c = 0; c < 64; c++) begin
         req      = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
         gpu_req  = req;
         gpu_addr = ADDR_W'($urandom);
         @(negedge clk);
         n_vec++; if (gpu_gnt !== req) begin n_err++; $display("FAIL gpu_rand_gnt c%0d: got %b want %b", c, gpu_gnt, req); end
         if (req) begin
            due_q.push_back(c + int'(RD_LAT) + 1);
            addr_q.push_back(gpu_addr);
         end
         exp_rv = (due_q.size() > 0) && (due_q[0] == c);
         n_vec++; if (gpu_rvalid !== exp_rv) begin n_err++; $display("FAIL gpu_rand_rvalid c%0d: got %b want %b", c, gpu_rvalid, exp_rv); end
         if (exp_rv) begin
            n_vec++; if (gpu_rdata !== ref_mem[addr_q[0]]) begin n_err++; $display("FAIL gpu_rand_data c%0d: got %h want %h", c, gpu_rdata, ref_mem[addr_q[0]]); end
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
         end
         tick();
      end
      n_vec++; if (due_q.size() != 0) begin n_err++; $display("FAIL gpu_rand_drain: got %0d pending want 0", due_q.size()); end
   endtask

   task automatic test_starvation;
      for (int it = 0; it < 2; it++) begin
         logic [ADDR_W-1:0] a;
         logic              cpu_turn, exp_grv;
         a = (it == 0) ? 11'h7FF : ADDR_W'($urandom);
         cpu_start(a, 8'h00, 1'b1, 1'b0);
         for (int c = 0; c < int'(CPU_MAX_WAIT) + int'(RD_LAT) + 4; c++) begin
            gpu_req  = 1'b1;
            gpu_addr = ADDR_W'($urandom);
            @(negedge clk);
            cpu_turn = (c == int'(CPU_MAX_WAIT));
            n_vec++; if (gpu_gnt !== ~cpu_turn) begin n_err++; $display("FAIL starve_gnt[%0d] c%0d: got %b want %b", it, c, gpu_gnt, ~cpu_turn); end
            n_vec++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, (cpu_turn ? a : gpu_addr)}) begin
               n_err++; $display("FAIL starve_ram[%0d] c%0d: got en%b we%b %h want addr %h", it, c, ram_en, ram_we, ram_addr, cpu_turn ? a : gpu_addr);
            end
            n_vec++; if (cpu_wait_n !== (c > int'(CPU_MAX_WAIT + RD_LAT))) begin n_err++; $display("FAIL starve_wait[%0d] c%0d: got %b", it, c, cpu_wait_n); end
            n_vec++; if (cpu_rvalid !== (c == int'(CPU_MAX_WAIT + RD_LAT) + 1)) begin n_err++; $display("FAIL starve_rvalid[%0d] c%0d: got %b", it, c, cpu_rvalid); end
            if (c == int'(CPU_MAX_WAIT + RD_LAT) + 1) begin
               n_vec++; if (cpu_rdata !== ref_mem[a]) begin n_err++; $display("FAIL starve_rdata[%0d]: got %h want %h", it, cpu_rdata, ref_mem[a]); end
            end
            exp_grv = (c >= int'(RD_LAT) + 1) && (c - int'(RD_LAT) - 1 != int'(CPU_MAX_WAIT));
            n_vec++; if (gpu_rvalid !== exp_grv) begin n_err++; $display("FAIL starve_gpu_rvalid[%0d] c%0d: got %b want %b", it, c, gpu_rvalid, exp_grv); end
            tick();
         end
         gpu_req = 1'b0;
         cpu_idle();
         repeat (3) tick();
      end
   endtask

   task automatic test_collision;
      for (int it = 0; it < 3; it++) begin
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] old_v, d;
         a     = ADDR_W'($urandom);
         old_v = ref_mem[a];
         d     = old_v ^ DATA_W'($urandom_range(1, 255));
         gpu_req = 1'b1; gpu_addr = a;
         cpu_start(a, d, 1'b0, 1'b1);
         @(negedge clk);
         n_vec++; if ({gpu_gnt, ram_we, cpu_wait_n} !== 3'b100) begin n_err++; $display("FAIL coll_c0[%0d]: got %b want 100", it, {gpu_gnt, ram_we, cpu_wait_n}); end
         tick();
         gpu_req = 1'b0;
         @(negedge clk);
         n_vec++; if ({gpu_gnt, ram_en, ram_we, ram_addr, ram_din} !== {3'b011, a, d}) begin
            n_err++; $display("FAIL coll_write[%0d]: got %b%b%b %h %h want 011 %h %h", it, gpu_gnt, ram_en, ram_we, ram_addr, ram_din, a, d);
         end
         tick();
         gpu_req = 1'b1;
         @(negedge clk);
         n_vec++; if ({gpu_rvalid, gpu_rdata, cpu_wait_n} !== {1'b1, old_v, 1'b1}) begin
            n_err++; $display("FAIL coll_old[%0d]: got rv%b %h w%b want %h", it, gpu_rvalid, gpu_rdata, cpu_wait_n, old_v);
         end
         tick();
         gpu_req = 1'b0;
         cpu_idle();
         ref_mem[a] = d;
         @(negedge clk);
         n_vec++; if (gpu_rvalid !== 1'b0) begin n_err++; $display("FAIL coll_gap[%0d]: got %b want 0", it, gpu_rvalid); end
         tick();
         @(negedge clk);
         n_vec++; if ({gpu_rvalid, gpu_rdata} !== {1'b1, ref_mem[a]}) begin n_err++; $display("FAIL coll_new[%0d]: got rv%b %h want %h", it, gpu_rvalid, gpu_rdata, ref_mem[a]); end
         tick();
      end
   endtask

   task automatic test_reset_midread;
      logic [ADDR_W-1:0] a;
      logic [40:0]       obs;
      a = ADDR_W'($urandom);
      cpu_start(a, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      n_vec++; if ({ram_en, ram_addr} !== {1'b1, a}) begin n_err++; $display("FAIL rst_mid_grant: got %b %h want 1 %h", ram_en, ram_addr, a); end
      tick();
      reset_n = 1'b0;
      #1;
      obs = {cpu_wait_n, gpu_gnt, ram_en, ram_we, ram_addr, ram_din, cpu_rdata, cpu_rvalid, gpu_rdata, gpu_rvalid};
      n_vec++; if (obs !== {1'b1, 40'b0}) begin n_err++; $display("FAIL rst_mid_outputs: got %h want %h", obs, {1'b1, 40'b0}); end
      repeat (2) tick();
      cpu_idle();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++; if ({cpu_rvalid, gpu_rvalid, cpu_wait_n, cpu_rdata} !== {3'b001, 8'h00}) begin
            n_err++; $display("FAIL rst_mid_after c%0d: got rv%b grv%b w%b %h want 001 00", c, cpu_rvalid, gpu_rvalid, cpu_wait_n, cpu_rdata);
         end
         tick();
      end
   endtask

   task automatic test_mreq_drop;
      logic [ADDR_W-1:0] a, b;
      a = ADDR_W'($urandom);
      b = ADDR_W'($urandom);
      cpu_start(a, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      n_vec++; if ({ram_en, ram_addr} !== {1'b1, a}) begin n_err++; $display("FAIL drop_grant: got %b %h want 1 %h", ram_en, ram_addr, a); end
      tick();
      cpu_mreq_n = 1'b1;
      @(negedge clk);
      n_vec++; if ({ram_en, cpu_wait_n, cpu_rvalid} !== 3'b010) begin n_err++; $display("FAIL drop_c1: got %b want 010", {ram_en, cpu_wait_n, cpu_rvalid}); end
      tick();
      @(negedge clk);
      n_vec++; if ({ram_en, cpu_rvalid, cpu_rdata} !== {2'b01, ref_mem[a]}) begin
         n_err++; $display("FAIL drop_return: got en%b rv%b %h want %h", ram_en, cpu_rvalid, cpu_rdata, ref_mem[a]);
      end
      tick();
      cpu_start(b, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      n_vec++; if ({ram_en, cpu_wait_n, ram_addr} !== {2'b10, b}) begin n_err++; $display("FAIL drop_fresh: got en%b w%b %h want %h", ram_en, cpu_wait_n, ram_addr, b); end
      tick();
      tick();
      @(negedge clk);
      n_vec++; if ({cpu_rvalid, cpu_wait_n, cpu_rdata} !== {2'b11, ref_mem[b]}) begin
         n_err++; $display("FAIL drop_fresh_return: got rv%b w%b %h want %h", cpu_rvalid, cpu_wait_n, cpu_rdata, ref_mem[b]);
      end
      cpu_idle();
      tick();
   endtask

   initial begin
      reset_n  = 1'b0;
      cpu_idle();
      cpu_addr = '0;
      cpu_dout = '0;
      gpu_req  = 1'b0;
      gpu_addr = '0;
      pl_we    = 1'b0;
      pl_addr  = '0;
      pl_data  = '0;
      test_reset();
      for (int i = 0; i < int'(DEPTH); i++) preload(ADDR_W'(i), DATA_W'($urandom));
      test_cpu_write();
      test_cpu_read();
      test_gpu_stream();
      test_gpu_random();
      test_starvation();
      test_collision();
      test_reset_midread();
      test_mreq_drop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
